// File: rtl/sbox_sequencer.sv
// sbox_sequencer: time-multiplexes one shared DES S-box lookup unit.
// A 48-bit round value (E(R) xor K) is accepted over a valid/ready handshake.
// Its eight 6-bit groups are then looked up one per cycle through the shared unit.
// The assembled 32-bit substitution is offered downstream over valid/ready.
module sbox_sequencer #(
    parameter int NUM_BOXES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [6*NUM_BOXES-1:0]       in_data,
    output logic [$clog2(NUM_BOXES)-1:0] sbox_sel,
    output logic [5:0]                   sbox_in,
    input  logic [3:0]                   sbox_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*NUM_BOXES-1:0]       out_data,
    output logic                         busy
);

    localparam int IW = 6 * NUM_BOXES;
    localparam int OW = 4 * NUM_BOXES;
    localparam int SW = $clog2(NUM_BOXES);
    localparam logic [SW-1:0] LAST_IDX = SW'(NUM_BOXES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   idx_reg;
    logic [IW-1:0]   data_reg;
    logic [OW-1:0]   out_data_reg;
    logic            out_valid_reg;
    logic            accept;
    logic [5:0]      group [NUM_BOXES];

    // Split the captured word into its 6-bit groups, S1 in the most significant bits
    generate
        for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_group
            assign group[gi] = data_reg[IW-1-6*gi -: 6];
        end
    endgenerate

    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: exactly NUM_BOXES RUN cycles, then hold in DONE until taken
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept)               state_next = RUN;
            RUN:  if (idx_reg == LAST_IDX)  state_next = DONE;
            DONE: if (out_ready)            state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Outputs: the lookup address is driven straight from registers during RUN
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        sbox_sel = '0;
        sbox_in  = '0;
        case (state_reg)
            IDLE: in_ready = !rst;
            RUN: begin
                busy     = 1'b1;
                sbox_sel = idx_reg;
                sbox_in  = group[idx_reg];
            end
            DONE: busy = 1'b1;
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: capture the word, collect one lookup nibble per RUN cycle, flag completion
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg       <= '0;
            data_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        data_reg <= in_data;
                        idx_reg  <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_BOXES; i++) begin
                        if (idx_reg == SW'(i)) begin
                            out_data_reg[OW-1-4*i -: 4] <= sbox_out;
                        end
                    end
                    // idx stays on the last box; the next accept rewinds it
                    if (idx_reg == LAST_IDX) begin
                        out_valid_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + SW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_sequencer.sv
// Bench for sbox_sequencer: drives the shared lookup with the full DES S-boxes.
// A cycle model built from the behavioural rules is compared every cycle.
// Directed tests pin known DES vectors, timing, backpressure, abort and back-to-back.
module tb_sbox_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic [2:0]  sbox_sel;
    logic [5:0]  sbox_in;
    logic [3:0]  sbox_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    always #5 clk = ~clk;

    sbox_sequencer #(.NUM_BOXES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sbox_sel  (sbox_sel),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // DES S1..S8, each 4 rows of 16 entries, row-major, first entry in the top nibble
    localparam logic [255:0] SBOX_TAB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC9035B6
    };

    function automatic logic [3:0] des_sbox(input int box, input logic [5:0] v);
        logic [255:0] t;
        int k;
        t = SBOX_TAB[box];
        k = int'({v[5], v[0]}) * 16 + int'(v[4:1]);
        return t[255-4*k -: 4];
    endfunction

    function automatic logic [5:0] grp(input logic [47:0] w, input int i);
        return w[47-6*i -: 6];
    endfunction

    function automatic logic [31:0] des_f(input logic [47:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[31-4*i -: 4] = des_sbox(i, grp(w, i));
        return r;
    endfunction

    // Shared lookup unit: combinational mux of the eight boxes
    assign sbox_out = des_sbox(int'(sbox_sel), sbox_in);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a word in flight takes one box per cycle, then waits to be taken
    int          cyc = 0;
    bit          m_inflight = 1'b0;
    int          m_k = 0;
    logic [47:0] m_word = '0;
    logic [31:0] m_out = '0;
    bit          m_valid = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_inflight = 1'b0;
                m_k        = 0;
                m_word     = '0;
                m_out      = '0;
                m_valid    = 1'b0;
                exp_q.delete();
            end else if (!m_inflight) begin
                if (in_valid) begin
                    m_inflight = 1'b1;
                    m_word     = in_data;
                    m_k        = 0;
                    exp_q.push_back(des_f(in_data));
                end
            end else if (m_k < 8) begin
                m_out[31-4*m_k -: 4] = des_sbox(m_k, grp(m_word, m_k));
                m_k++;
                if (m_k == 8) m_valid = 1'b1;
            end else if (out_ready) begin
                m_inflight = 1'b0;
                m_valid    = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, plus end-to-end scoreboard at the out handshake
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("in_ready", 64'(in_ready), 64'(!m_inflight && !rst));
                check("busy", 64'(busy), 64'(m_inflight));
                check("out_valid", 64'(out_valid), 64'(m_valid));
                check("out_data", 64'(out_data), 64'(m_out));
                if (m_inflight && m_k < 8) begin
                    check("sbox_sel", 64'(sbox_sel), 64'(m_k));
                    check("sbox_in", 64'(sbox_in), 64'(grp(m_word, m_k)));
                end else begin
                    check("sbox_sel_idle", 64'(sbox_sel), 64'd0);
                    check("sbox_in_idle", 64'(sbox_in), 64'd0);
                end
                if (m_valid && out_ready && !rst) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_empty", 64'd1, 64'd0);
                    end else begin
                        check("result", 64'(out_data), 64'(exp_q[0]));
                        $display("out word %h at cycle %0d", out_data, cyc);
                        got_q.push_back(out_data);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    logic [5:0] seq [8] = '{6'h18, 6'h11, 6'h1E, 6'h3A, 6'h21, 6'h26, 6'h14, 6'h27};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a word and wait (bounded) for it to be accepted; returns the accept cycle
    task automatic accept_word(input logic [47:0] w, output int acc);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(ok), 64'd1);
        tick();
        acc = cyc;
        $display("accept word %h at cycle %0d", w, acc);
    endtask

    task automatic run_word(input logic [47:0] w, input logic [31:0] exp, input bit use_seq, input int hold);
        int acc;
        logic [63:0] r;
        tick();
        got_q.delete();
        out_ready = (hold == 0);
        accept_word(w, acc);
        in_valid = 1'b0;
        r = {$urandom(), $urandom()};
        in_data = r[47:0];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("run_sel", 64'(sbox_sel), 64'(i));
            check("run_sbox_in", 64'(sbox_in), use_seq ? 64'(seq[i]) : 64'd0);
        end
        @(negedge clk);
        check("latency", 64'(cyc - acc), 64'd8);
        check("done_valid", 64'(out_valid), 64'd1);
        check("done_data", 64'(out_data), 64'(exp));
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(exp));
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
            tick();
            out_ready = 1'b1;
            @(negedge clk);
            check("release_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        check("after_valid", 64'(out_valid), 64'd0);
        check("after_in_ready", 64'(in_ready), 64'd1);
        if (got_q.size() == 0) check("got_word", 64'd0, 64'd1);
        else check("got_word", 64'(got_q.pop_front()), 64'(exp));
    endtask

    // Two words in a row; in_valid stays high throughout the first word
    task automatic b2b(input logic [47:0] w1, input logic [31:0] e1,
                       input logic [47:0] w2, input logic [31:0] e2, input bit noisy);
        int a1, a2;
        bit ok;
        logic [63:0] r;
        tick();
        got_q.delete();
        out_ready = 1'b1;
        accept_word(w1, a1);
        for (int k = 0; k < 9; k++) begin
            r = {$urandom(), $urandom()};
            in_data = noisy ? r[47:0] : w2;
            @(negedge clk);
            check("no_reaccept", 64'(in_ready), 64'd0);
            tick();
        end
        accept_word(w2, a2);
        in_valid = 1'b0;
        check("accept_spacing", 64'(a2 - a1), 64'd10);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (got_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b_timeout", 64'(ok), 64'd1);
        if (ok) begin
            check("b2b_first", 64'(got_q[0]), 64'(e1));
            check("b2b_second", 64'(got_q[1]), 64'(e2));
        end
    endtask

    task automatic abort_test();
        int acc, spurious;
        tick();
        got_q.delete();
        out_ready = 1'b1;
        accept_word(48'h6117BA866527, acc);
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("abort_in_ready_rst", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_data", 64'(out_data), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        spurious = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("abort_spurious", 64'(spurious), 64'd0);
        check("abort_no_output", 64'(got_q.size()), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_sel", 64'(sbox_sel), 64'd0);
        rst = 1'b0;
        // The model itself is pinned to known DES values
        check("model_zero", 64'(des_f(48'h0)), 64'hEFA72C4D);
        check("model_round1", 64'(des_f(48'h6117BA866527)), 64'h5C82B597);

        run_word(48'h0, 32'hEFA72C4D, 1'b0, 0);
        run_word(48'h6117BA866527, 32'h5C82B597, 1'b1, 0);
        run_word(48'h6117BA866527, 32'h5C82B597, 1'b1, 5);
        b2b(48'h6117BA866527, 32'h5C82B597, 48'h0, 32'hEFA72C4D, 1'b1);
        abort_test();
        b2b(48'h0, 32'hEFA72C4D, 48'h6117BA866527, 32'h5C82B597, 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
